// File: rtl/store_buffer.sv
// store_buffer: FIFO write buffer in front of the single data RAM port.
// CPU stores are queued and drained into the RAM one per cycle whenever
// no load needs the port. A load that overlaps a queued store waits
// until that store has drained, so loads always see older stores.
// Optional feature macro: STB_FORWARD_EN. When it is defined, a load
// whose youngest overlapping entry has the same address and mode is
// answered straight from the queue in the same cycle.
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic                      st_valid,
    output logic                      st_ready,
    input  logic [ADDR_W-1:0]         st_addr,
    input  logic [1:0]                st_mode,
    input  logic [DATA_W-1:0]         st_data,
    input  logic                      ld_valid,
    input  logic [ADDR_W-1:0]         ld_addr,
    input  logic [1:0]                ld_mode,
    output logic                      ld_ready,
    output logic [DATA_W-1:0]         ld_data,
    input  logic                      flush,
    output logic                      flush_done,
    output logic                      misalign,
    output logic                      mem_write,
    output logic [1:0]                mem_mode,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int SPAN_W = ADDR_W + 1;

    localparam logic [1:0] MODE_WORD = 2'b00;
    localparam logic [1:0] MODE_HALF = 2'b01;
    localparam logic [1:0] MODE_BYTE = 2'b10;

    localparam logic [1:0] OWN_IDLE  = 2'd0;
    localparam logic [1:0] OWN_DRAIN = 2'd1;
    localparam logic [1:0] OWN_LOAD  = 2'd2;

    // Number of bytes touched by an access of the given mode.
    function automatic logic [SPAN_W-1:0] span(input logic [1:0] mode);
        case (mode)
            MODE_WORD: span = SPAN_W'(4);
            MODE_HALF: span = SPAN_W'(2);
            default:   span = SPAN_W'(1);
        endcase
    endfunction

    // Keep only the bytes a store of this mode actually writes.
    function automatic logic [DATA_W-1:0] keep_bits(input logic [DATA_W-1:0] data,
                                                    input logic [1:0] mode);
        case (mode)
            MODE_WORD: keep_bits = data;
            MODE_HALF: keep_bits = data & DATA_W'(32'h0000_ffff);
            default:   keep_bits = data & DATA_W'(32'h0000_00ff);
        endcase
    endfunction

    // Natural alignment check; the reserved mode is never acceptable.
    function automatic logic is_aligned(input logic [1:0] low, input logic [1:0] mode);
        case (mode)
            MODE_WORD: is_aligned = (low == 2'b00);
            MODE_HALF: is_aligned = !low[0];
            MODE_BYTE: is_aligned = 1'b1;
            default:   is_aligned = 1'b0;
        endcase
    endfunction

    logic [ADDR_W-1:0] ent_addr [DEPTH];
    logic [1:0]        ent_mode [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];

    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic              full;
    logic              empty;
    logic              st_fire;
    logic              st_ok;
    logic              push;
    logic              pop;
    logic [DEPTH-1:0]  slot_ovl;
    logic              any_ovl;
    logic [1:0]        owner;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    // Store-side handshake: a full queue stays full even if it drains this cycle.
    always_comb begin
        full     = (count == CNT_W'(DEPTH));
        empty    = (count == '0);
        st_ready = !full && !flush;
        st_fire  = st_valid && st_ready;
        st_ok    = is_aligned(st_addr[1:0], st_mode);
        push     = st_fire && st_ok;
    end

    // Per physical slot: is it occupied, and does its byte range meet the load's range.
    always_comb begin
        slot_ovl = '0;
        for (int j = 0; j < DEPTH; j++) begin
            slot_ovl[j] = ({1'b0, PTR_W'(j) - rd_ptr} < count)
                       && ({1'b0, ld_addr} < ({1'b0, ent_addr[j]} + span(ent_mode[j])))
                       && ({1'b0, ent_addr[j]} < ({1'b0, ld_addr} + span(ld_mode)));
        end
        any_ovl = |slot_ovl;
    end

`ifdef STB_FORWARD_EN
    logic [PTR_W-1:0] young_slot;
    logic             young_exact;

    // Walk oldest to youngest; only an exact match on the youngest overlap may forward.
    always_comb begin
        young_slot = rd_ptr;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_ovl[rd_ptr + PTR_W'(i)]) begin
                young_slot = rd_ptr + PTR_W'(i);
            end
        end
        young_exact = (ent_addr[young_slot] == ld_addr) && (ent_mode[young_slot] == ld_mode);
        fwd_hit     = ld_valid && any_ovl && young_exact;
        fwd_data    = ent_data[young_slot];
    end
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

    // RAM port arbitration: a clean load wins, otherwise the queue head drains.
    always_comb begin
        owner = OWN_IDLE;
        if (ld_valid && !any_ovl) begin
            owner = OWN_LOAD;
        end else if (!empty) begin
            owner = OWN_DRAIN;
        end
        pop = (owner == OWN_DRAIN);
    end

    // Drive the RAM port and the load response from the chosen owner.
    always_comb begin
        mem_write = 1'b0;
        mem_mode  = 2'b00;
        mem_addr  = '0;
        mem_wdata = '0;
        ld_ready  = 1'b0;
        ld_data   = '0;
        case (owner)
            OWN_DRAIN: begin
                mem_write = 1'b1;
                mem_mode  = ent_mode[rd_ptr];
                mem_addr  = ent_addr[rd_ptr];
                mem_wdata = ent_data[rd_ptr];
            end
            OWN_LOAD: begin
                mem_mode  = ld_mode;
                mem_addr  = ld_addr;
                ld_ready  = 1'b1;
                ld_data   = mem_rdata;
            end
            default: ;
        endcase
        if (fwd_hit) begin
            ld_ready = 1'b1;
            ld_data  = fwd_data;
        end
    end

    assign flush_done = flush && empty;

    // Queue bookkeeping; reset throws away every queued store at once.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            misalign <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count    <= count + CNT_W'(push) - CNT_W'(pop);
            misalign <= st_fire && !st_ok;
        end
    end

    // Entry storage; contents are only meaningful while counted as occupied.
    always_ff @(posedge CLK) begin
        if (push) begin
            ent_addr[wr_ptr] <= st_addr;
            ent_mode[wr_ptr] <= st_mode;
            ent_data[wr_ptr] <= keep_bits(st_data, st_mode);
        end
    end

endmodule
